// File: rtl/crono_pkg.sv
// Shared stopwatch definitions: counter command codes and control FSM states.
package crono_pkg;

  localparam logic [1:0] EST_PARA  = 2'd0;
  localparam logic [1:0] EST_PAUSE = 2'd1;
  localparam logic [1:0] EST_RESET = 2'd2;
  localparam logic [1:0] EST_CONTA = 2'd3;

  typedef enum logic [1:0] {ZERADO, CONTANDO, VOLTA, PARADO} state_t;

  // Counter command issued while the FSM sits in a given state.
  function automatic logic [1:0] est_of(state_t s);
    case (s)
      ZERADO:   est_of = EST_RESET;
      CONTANDO: est_of = EST_CONTA;
      VOLTA:    est_of = EST_PAUSE;
      default:  est_of = EST_PARA;
    endcase
  endfunction

endpackage

// File: rtl/crono_ctrl_if.sv
// Button inputs and counter-command outputs of the stopwatch controller.
interface crono_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic [1:0] estado;
  logic       running;
  logic       lap_active;
  logic       hold_rst;

  modport master (output btn_start, btn_lap,
                  input  estado, running, lap_active, hold_rst);
  modport slave  (input  btn_start, btn_lap,
                  output estado, running, lap_active, hold_rst);
endinterface

// File: rtl/crono_debounce.sv
// One button: 2-FF synchroniser, stable-count debounce, registered press pulse.
module crono_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic deb,
  output logic press
);
  localparam int DW = $clog2(DEB_CYCLES);

  logic          sync1, sync, deb_d;
  logic [DW-1:0] cnt;

  // Synchronise, require DEB_CYCLES consecutive differing cycles, then flag the rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync  <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      if (sync != deb) begin
        if (cnt == DW'(DEB_CYCLES - 1)) begin
          deb <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/crono_ctrl.sv
// Stopwatch control: debounced buttons, lap long-press reset, mode FSM.
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic         clk,
  input  logic         rst_n,
  crono_ctrl_if.slave  bus
);
  localparam int HW = $clog2(HOLD_CYCLES);

  logic          start_deb, start_p, lap_deb, lap_p;
  logic [HW-1:0] hold_cnt;
  logic          hold_fire;
  state_t        state;
  logic [1:0]    estado;
  logic          running, lap_active;

  crono_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_start), .deb(start_deb), .press(start_p)
  );

  crono_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_lap), .deb(lap_deb), .press(lap_p)
  );

  // Long-press timer; saturates at HOLD_CYCLES-1 so it fires once per hold.
  // hold_fire is high exactly in the cycle hold_cnt first sits at HOLD_CYCLES-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      hold_fire <= 1'b0;
    end else begin
      hold_fire <= lap_deb && (hold_cnt == HW'(HOLD_CYCLES - 2));
      if (!lap_deb)
        hold_cnt <= '0;
      else if (hold_cnt != HW'(HOLD_CYCLES - 1))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Mode FSM with registered output decode; long press beats start beats lap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ZERADO;
      estado     <= EST_RESET;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      estado     <= est_of(state);
      running    <= (state == CONTANDO) || (state == VOLTA);
      lap_active <= (state == VOLTA);
      if (hold_fire) begin
        state <= ZERADO;
      end else if (start_p) begin
        case (state)
          ZERADO, PARADO: state <= CONTANDO;
          default:        state <= PARADO;
        endcase
      end else if (lap_p) begin
        case (state)
          CONTANDO: state <= VOLTA;
          VOLTA:    state <= CONTANDO;
          PARADO:   state <= ZERADO;
          default:  state <= state;
        endcase
      end
    end
  end

  assign bus.estado     = estado;
  assign bus.running    = running;
  assign bus.lap_active = lap_active;
  assign bus.hold_rst   = hold_fire;

  // Start level is only consumed through its press pulse.
  logic unused_start_deb;
  assign unused_start_deb = start_deb;
endmodule

// File: tb/tb_crono_ctrl.sv
// Directed bench for crono_ctrl with DEB_CYCLES=4, HOLD_CYCLES=20.
module tb_crono_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  crono_ctrl_if bus();

  always #5 clk = ~clk;

  crono_ctrl #(.DEB_CYCLES(4), .HOLD_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // Advance n clock edges, leaving time at 1 unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the chosen buttons for n cycles, release, and let everything settle.
  task automatic press(input logic s, input logic l, input int n);
    bus.btn_start = s;
    bus.btn_lap   = l;
    cyc(n);
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
    cyc(12);
  endtask

  int bad, pulses, at, saw_pause;
  logic [1:0] est26, est27;

  initial begin
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_estado", bus.estado, 2);
    chk("rst_running", bus.running, 0);
    chk("rst_lap", bus.lap_active, 0);
    chk("rst_hold", bus.hold_rst, 0);
    cyc(10);
    chk("idle_estado", bus.estado, 2);

    // start latency: 2 + 4 + 1 + 1 + 1 = 9 edges
    bus.btn_start = 1'b1;
    cyc(8);
    chk("lat_8", bus.estado, 2);
    cyc(1);
    chk("lat_9", bus.estado, 3);
    chk("lat_running", bus.running, 1);
    cyc(1);
    bus.btn_start = 1'b0;
    cyc(12);
    press(1, 0, 10);
    chk("stop_estado", bus.estado, 0);
    chk("stop_running", bus.running, 0);

    // lap sequence
    press(1, 0, 10);
    chk("restart", bus.estado, 3);
    press(0, 1, 8);
    chk("lap_estado", bus.estado, 1);
    chk("lap_active", bus.lap_active, 1);
    chk("lap_running", bus.running, 1);
    press(0, 1, 8);
    chk("unlap_estado", bus.estado, 3);
    chk("unlap_active", bus.lap_active, 0);
    press(1, 0, 10);
    chk("stop2", bus.estado, 0);
    press(0, 1, 8);
    chk("clear", bus.estado, 2);

    // glitch rejection: 3-cycle pulse then 2-cycle toggling
    bad = 0;
    bus.btn_start = 1'b1;
    repeat (3) begin cyc(1); if (bus.estado !== 2'd2) bad++; end
    bus.btn_start = 1'b0;
    repeat (10) begin
      repeat (2) begin cyc(1); if (bus.estado !== 2'd2) bad++; end
      bus.btn_start = ~bus.btn_start;
    end
    bus.btn_start = 1'b0;
    repeat (12) begin cyc(1); if (bus.estado !== 2'd2) bad++; end
    chk("glitch_bad", bad, 0);
    chk("glitch_estado", bus.estado, 2);

    // long press from CONTANDO
    press(1, 0, 10);
    chk("lp_start", bus.estado, 3);
    pulses = 0; at = -1; saw_pause = 0;
    bus.btn_lap = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (bus.hold_rst === 1'b1) begin pulses++; at = i; end
      if (bus.estado === 2'd1) saw_pause = 1;
      if (i == 26) est26 = bus.estado;
      if (i == 27) est27 = bus.estado;
    end
    bus.btn_lap = 1'b0;
    cyc(12);
    chk("lp_pause_seen", saw_pause, 1);
    chk("lp_pulses", pulses, 1);
    chk("lp_pulse_at", at, 25);
    chk("lp_est26", est26, 1);
    chk("lp_est27", est27, 2);
    chk("lp_estado", bus.estado, 2);

    // re-hold after release fires again, once
    pulses = 0;
    bus.btn_lap = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (bus.hold_rst === 1'b1) pulses++;
    end
    bus.btn_lap = 1'b0;
    cyc(12);
    chk("rehold_pulses", pulses, 1);
    chk("rehold_estado", bus.estado, 2);

    // simultaneous presses in PARADO: start wins
    press(1, 0, 10);
    press(1, 0, 10);
    chk("sim_parado", bus.estado, 0);
    press(1, 1, 10);
    chk("sim_estado", bus.estado, 3);
    chk("sim_lap", bus.lap_active, 0);

    // reset mid-debounce discards progress
    bus.btn_start = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    bus.btn_start = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(15);
    chk("rst_mid_estado", bus.estado, 2);

    // button held through reset release presses after a fresh debounce
    bus.btn_start = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("held_early", bus.estado, 2);
    cyc(12);
    bus.btn_start = 1'b0;
    cyc(12);
    chk("held_estado", bus.estado, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/crono_ctrl.md
Name: crono_ctrl

Overview:
- Control FSM for the stopwatch counter datapath; drives the counter's 2-bit `estado` command input (0=para, 1=pause, 2=reset, 3=conta).
- Takes two raw push-buttons and turns them into stopwatch modes: idle/zeroed, running, lap (display frozen, count continues), stopped.
- Each button is synchronised and debounced; rising edges and a long-press on the lap button are detected.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required before a debounced level changes (>=2).
- HOLD_CYCLES, 100000000: cycles the debounced lap button must stay high to force a reset (> DEB_CYCLES).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- btn_start  input  1  raw start/stop button, active high, asynchronous
- btn_lap  input  1  raw lap/reset button, active high, asynchronous
- estado  output  2  command to stopwatch counter: 0=para, 1=pause, 2=reset, 3=conta
- running  output  1  high while the count advances (CONTANDO, VOLTA)
- lap_active  output  1  high in VOLTA
- hold_rst  output  1  one-cycle pulse when a long-press reset fires

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to ZERADO; estado=2, running=0, lap_active=0, hold_rst=0.
  - Synchronisers, debounced levels and all counters clear to 0.
- Input path, per button:
  - 2-FF synchroniser produces `sync`.
  - A counter increments each cycle while sync != deb and clears when they are equal.
  - When the counter equals DEB_CYCLES-1 and sync still differs, deb <= sync and the counter clears.
  - deb therefore changes exactly DEB_CYCLES cycles after sync first differs.
  - A glitch shorter than DEB_CYCLES produces no change.
  - The press pulse is registered: high one cycle, on the cycle after deb rises. Release generates no event.
- Long press:
  - hold_cnt increments each cycle while lap deb=1 and clears when deb=0.
  - When hold_cnt reaches HOLD_CYCLES-1, hold_rst pulses for one cycle.
  - The counter then saturates, so there is no repeat until release.
- FSM (state register updates on the edge where a press pulse is high; outputs are a registered decode of state):
  - ZERADO, estado=2: start -> CONTANDO; lap ignored.
  - CONTANDO, estado=3: start -> PARADO; lap -> VOLTA.
  - VOLTA, estado=1 (counter keeps counting with display frozen): lap -> CONTANDO; start -> PARADO.
  - PARADO, estado=0: start -> CONTANDO; lap -> ZERADO.
- Priority:
  - hold_rst overrides everything and forces ZERADO from any state. The short-press lap action has already occurred on the earlier press edge.
  - If start and lap press pulses occur in the same cycle, start wins and lap is dropped.
- Latency from a clean raw edge to the estado change: 2 (sync) + DEB_CYCLES + 1 (pulse) + 1 (state) + 1 (output register) cycles.
- ZERADO holds estado=2 for at least one cycle (indefinitely until start), so the counter clears.
- Reset mid-debounce or mid-hold: all progress is discarded, and the button must be seen stable again after reset.
- A button held high through reset release produces a press pulse once its debounce completes. This is intended.

Decomposition:
- Shared package crono_pkg holds:
  - estado codes: EST_PARA=2'd0, EST_PAUSE=2'd1, EST_RESET=2'd2, EST_CONTA=2'd3.
  - FSM state type (ZERADO, CONTANDO, VOLTA, PARADO).
- Counter and FSM blocks both import the estado codes.
- One sub-module, crono_debounce (synchroniser + debounce counter + press pulse, parameter DEB_CYCLES), is instantiated once per button.
- Hold counter and FSM live in crono_ctrl.

Test Plan:
- Reset behaviour, DEB_CYCLES=4, HOLD_CYCLES=20: hold rst_n=0 for 3 cycles, release -> estado=2, running=0, lap_active=0, hold_rst=0, with no change while both buttons are low.
- Start press: btn_start high for 10 cycles -> estado becomes 3 exactly 2+4+1+1+1=9 cycles after the raw edge, and running=1. A second press -> estado=0, running=0.
- Lap sequence: from estado=3, short lap press (8 cycles) -> estado=1, lap_active=1. Second press -> estado=3. Then start -> 0, then lap -> 2.
- Glitch rejection: btn_start high for 3 cycles, low, then toggled every 2 cycles for 20 cycles -> no press pulse and estado unchanged.
- Long press: in CONTANDO, hold btn_lap high for 40 cycles -> estado first goes to 1 (short press), then hold_rst pulses exactly once at hold_cnt=19, estado=2. No second pulse until release and re-hold.
- Simultaneous and reset cases:
  - In PARADO, both buttons rise on the same cycle -> estado=3 (start wins).
  - rst_n=0 mid-debounce -> no late pulse after reset release unless the button stays high for a further 4 cycles.
